// File: rtl/csync_pkg.sv
// csync_pkg: shared pulse-class and FSM types plus lock constants for the composite-sync decoder.
package csync_pkg;
  typedef enum logic [1:0] {GLITCH, LINE, INVALID, BROAD} pulse_class_e;
  typedef enum logic {HIGH, LOW} state_e;
  localparam logic [3:0] LOCK_COUNT = 4'd8;
  localparam int LOCK_TOL = 4;
endpackage

// File: rtl/csync_pulse_meas.sv
// csync_pulse_meas: synchronizes csync, measures each low pulse and emits one-clock class strobes.
module csync_pulse_meas
  import csync_pkg::*;
#(
  parameter int HS_MIN = 4,
  parameter int HS_MAX = 16,
  parameter int VS_MIN = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic csync_i,
  output logic line_o,
  output logic invalid_o,
  output logic broad_o
);
  logic [1:0] sync_q, fill_q;
  state_e state_q, state_d;
  logic [9:0] width_q, width_d;
  logic armed_q, armed_d, cs_s, done;
  int w;
  pulse_class_e cls;
  assign cs_s = sync_q[1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b11;
      fill_q  <= 2'b00;
      state_q <= HIGH;
      width_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], csync_i};
      fill_q  <= {fill_q[0], 1'b1};
      state_q <= state_d;
      width_q <= width_d;
      armed_q <= armed_d;
    end
  end
  // armed only once a genuine high is seen, so a pulse cut by reset is never measured
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    done    = 1'b0;
    armed_d = armed_q | (fill_q[1] & cs_s);
    w       = int'(width_q) + 1;
    if (state_q == HIGH) begin
      if (!cs_s && armed_q) begin
        state_d = LOW;
        width_d = '0;
      end
    end else if (cs_s) begin
      state_d = HIGH;
      done    = 1'b1;
    end else begin
      width_d = (width_q == '1) ? width_q : width_q + 10'd1;
    end
    cls = (w < HS_MIN) ? GLITCH : (w <= HS_MAX) ? LINE : (w < VS_MIN) ? INVALID : BROAD;
  end
  assign line_o    = done && cls == LINE;
  assign invalid_o = done && cls == INVALID;
  assign broad_o   = done && cls == BROAD;
endmodule

// File: rtl/csync_decoder.sv
// csync_decoder: regenerates line/frame timing from composite sync.
// Define CSYNC_FLYWHEEL_EN to insert hsync for missing line pulses while locked.
module csync_decoder
  import csync_pkg::*;
#(
  parameter int LINE_CLKS    = 128,
  parameter int HS_MIN       = 4,
  parameter int HS_MAX       = 16,
  parameter int VS_MIN       = 32,
  parameter int LINE_MIN     = 96,
  parameter int HBLANK_CLKS  = 24,
  parameter int VBLANK_LINES = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       csync,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       frame_start,
  output logic       locked,
  output logic       err_pulse
);
  logic line_s, inv_s, broad_s;
  logic [9:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [3:0] cnt_q, cnt_d;
  logic hsync_q, vsync_q, vsync_d, fs_q, locked_q, locked_d, err_q, seen_q, seen_d;
  logic acc, in_tol, miss, ins, hs, fs;
  int tmr;
`ifdef CSYNC_FLYWHEEL_EN
  logic [1:0] fly_q, fly_d;
`endif
  csync_pulse_meas #(.HS_MIN(HS_MIN), .HS_MAX(HS_MAX), .VS_MIN(VS_MIN)) u_meas (
    .clk(clk), .reset_n(reset_n), .csync_i(csync),
    .line_o(line_s), .invalid_o(inv_s), .broad_o(broad_s)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xpos_q   <= '0;
      ypos_q   <= '0;
      cnt_q    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      seen_q   <= 1'b0;
`ifdef CSYNC_FLYWHEEL_EN
      fly_q    <= '0;
`endif
    end else begin
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      cnt_q    <= cnt_d;
      hsync_q  <= hs;
      vsync_q  <= vsync_d;
      fs_q     <= fs;
      locked_q <= locked_d;
      err_q    <= inv_s;
      seen_q   <= seen_d;
`ifdef CSYNC_FLYWHEEL_EN
      fly_q    <= fly_d;
`endif
    end
  end
  // tmr is the hsync spacing this clock's event would produce
  always_comb begin
    tmr      = int'(xpos_q) + 1;
    acc      = line_s && tmr >= LINE_MIN;
    in_tol   = tmr >= LINE_CLKS - LOCK_TOL && tmr <= LINE_CLKS + LOCK_TOL;
    miss     = locked_q && !acc && tmr == LINE_CLKS + LOCK_TOL;
    cnt_d    = cnt_q;
    locked_d = locked_q;
`ifdef CSYNC_FLYWHEEL_EN
    ins   = miss;
    fly_d = acc ? 2'd0 : fly_q;
    if (miss) begin
      fly_d = fly_q + 2'd1;
      if (fly_q == 2'd2) begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    end
`else
    ins = 1'b0;
    if (miss) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end
`endif
    hs = acc | ins;
    if (acc) begin
      cnt_d    = !in_tol ? 4'd1 : (cnt_q == LOCK_COUNT) ? cnt_q : cnt_q + 4'd1;
      locked_d = cnt_d == LOCK_COUNT;
    end
    if (inv_s) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end
    fs      = broad_s && seen_q;
    seen_d  = acc ? 1'b1 : broad_s ? 1'b0 : seen_q;
    vsync_d = broad_s ? 1'b1 : acc ? 1'b0 : vsync_q;
    xpos_d  = hs ? '0 : (xpos_q == '1) ? xpos_q : xpos_q + 10'd1;
    ypos_d  = fs ? '0 : !hs ? ypos_q : (ypos_q == '1) ? ypos_q : ypos_q + 10'd1;
  end
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign hblank      = int'(xpos_q) < HBLANK_CLKS;
  assign vblank      = int'(ypos_q) < VBLANK_LINES;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err_pulse   = err_q;
endmodule

// File: doc/csync_decoder.md
CSYNC_DECODER -- requirements
Module: csync_decoder

Interface
REQ-001 SHALL have parameter LINE_CLKS, default 128, nominal clocks per scan line.
REQ-002 SHALL have parameter HS_MIN, default 4, shortest low pulse accepted as sync; shorter pulses are glitches.
REQ-003 SHALL have parameter HS_MAX, default 16, longest low pulse classified as line sync.
REQ-004 SHALL have parameter VS_MIN, default 32, shortest low pulse classified as broad (vertical) pulse.
REQ-005 SHALL have parameter LINE_MIN, default 96, minimum clocks between accepted line syncs.
REQ-006 SHALL have parameters HBLANK_CLKS, default 24, and VBLANK_LINES, default 20.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 csync  input  1  composite sync, active-low, asynchronous to clk.
REQ-010 hsync  output  1  regenerated line sync, active-high, 1 clock wide.
REQ-011 vsync  output  1  vertical sync level, active-high.
REQ-012 hblank, vblank  output  1 each  blanking flags.
REQ-013 xpos, ypos  output  10 each  pixel clock count in line; line count in frame.
REQ-014 frame_start  output  1  one-clock strobe at frame start.
REQ-015 locked  output  1  line timing stable.
REQ-016 err_pulse  output  1  one-clock strobe on pulse classified invalid.

Function
REQ-017 SHALL pass csync through a 2-flop synchronizer; all timing below refers to the synchronized signal (cs_s).
REQ-018 SHALL use FSM {HIGH, LOW}: HIGH->LOW on cs_s=0, clearing width counter; LOW counts clocks; LOW->HIGH on cs_s=1, classifying that cycle.
REQ-019 Classification: width<HS_MIN glitch (ignored, no strobe); HS_MIN..HS_MAX line; HS_MAX+1..VS_MIN-1 invalid (err_pulse); >=VS_MIN broad.
REQ-020 Width counter SHALL saturate at 1023, never wrap.
REQ-021 Line pulse SHALL be accepted only if line timer >=LINE_MIN, else ignored (equalizing half-line pulses).
REQ-022 Accepted line pulse: hsync=1 the clock after classification; xpos=0 same clock; ypos+1, saturating at 1023.
REQ-023 xpos SHALL increment every clock otherwise, saturating at 1023.
REQ-024 hblank SHALL be 1 while xpos<HBLANK_CLKS; vblank 1 while ypos<VBLANK_LINES.
REQ-025 Broad pulse: vsync=1 next clock; first broad pulse after a line pulse sets ypos=0 and frame_start=1 for one clock.
REQ-026 vsync SHALL clear on next accepted line pulse, same clock as hsync.
REQ-027 locked SHALL set after 8 consecutive accepted line pulses with spacing LINE_CLKS±4; SHALL clear on err_pulse or spacing outside tolerance.
REQ-028 Pulse ending in same clock as flywheel insertion (REQ-031): real pulse wins, one hsync only.

Reset
REQ-029 reset_n low SHALL asynchronously force: FSM HIGH, synchronizer 1s, counters 0, all outputs 0; hblank, vblank 1.
REQ-030 Reset mid-pulse SHALL discard that pulse; after release, first pulse classified only after a full HIGH->LOW->HIGH.

Configuration
REQ-031 Macro CSYNC_FLYWHEEL_EN defined: while locked, if line timer reaches LINE_CLKS+4 with no accepted line pulse, SHALL insert hsync as in REQ-022 and clear locked after 3 consecutive insertions; undefined: no insertion, missing pulse only clears locked.

Structure
REQ-032 Shared package csync_pkg SHALL hold pulse-class enum {GLITCH, LINE, INVALID, BROAD}, FSM state type, LOCK_COUNT=8, LOCK_TOL=4.
REQ-033 Sub-module csync_pulse_meas SHALL contain synchronizer, FSM and width classifier, emitting one-clock class strobes.

Verification
REQ-034 csync low 8 clocks every 128 -> hsync pulses 128 apart, 3 clocks after rising input edge; locked=1 after 8th.
REQ-035 Low 2 clocks mid-line -> no hsync, no err_pulse, xpos continues.
REQ-036 Low 24 clocks -> err_pulse=1 one clock; locked 1->0.
REQ-037 Three 40-clock broad pulses then line pulses -> frame_start once, ypos=0, vsync high until first line hsync.
REQ-038 Locked, one line pulse omitted -> with CSYNC_FLYWHEEL_EN hsync at 132 clocks, locked stays 1; without, no hsync, locked=0.
REQ-039 reset_n low during 10-clock low pulse -> outputs reset immediately; no hsync from that pulse after release.
